// File: rtl/lock_key_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : lock_key_loader_if
//  Purpose  : Serial key-frame link feeding lock_key_loader. The master opens
//             a frame with a start pulse, then streams key/parity bits over
//             a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface lock_key_loader_if;
  logic start;
  logic key_bit;
  logic key_bit_vld;
  logic key_bit_rdy;

  modport master (
    output start,
    output key_bit,
    output key_bit_vld,
    input  key_bit_rdy
  );

  modport slave (
    input  start,
    input  key_bit,
    input  key_bit_vld,
    output key_bit_rdy
  );
endinterface
`default_nettype wire

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
//  Module   : lock_key_loader
//  Purpose  : Receives an even-parity-protected serial unlock key and drives
//             the key inputs of the locked core. A wrong default key is shown
//             until a frame passes parity; MAX_FAIL consecutive bad frames
//             latch a lockout that only reset clears.
//  Revision : 1.0  initial release
// ============================================================================
module lock_key_loader #(
  parameter int               KEY_W       = 4,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = {KEY_W{1'b0}},
  parameter int               TIMEOUT     = 16,
  parameter int               MAX_FAIL    = 3
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  lock_key_loader_if.slave                   link,
  output logic [KEY_W-1:0]                   key_out,
  output logic                               key_valid,
  output logic                               busy,
  output logic                               err,
  output logic                               lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt
);

  localparam int BW = $clog2(KEY_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [BW-1:0] LAST_BIT_C  = BW'(KEY_W - 1);
  localparam logic [TW-1:0] TIMEOUT_C   = TW'(TIMEOUT);
  localparam logic [FW-1:0] MAX_FAIL_C  = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_PARITY  = 3'd2,
    S_COMMIT  = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t           state_q,     state_d;
  logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [TW-1:0]    timer_q,     timer_d;
  logic [KEY_W-1:0] shadow_q,    shadow_d;
  logic [KEY_W-1:0] key_out_q,   key_out_d;
  logic             key_valid_q, key_valid_d;
  logic             err_q,       err_d;
  logic [FW-1:0]    fail_cnt_q,  fail_cnt_d;

  logic             rdy;
  logic             xfer;
  logic             parity_ok;
  logic [TW-1:0]    timer_inc;
  logic [FW-1:0]    fail_inc;

  // Only the two receiving states accept bits; everything else stalls the link.
  assign rdy       = (state_q == S_SHIFT) || (state_q == S_PARITY);
  assign xfer      = link.key_bit_vld && rdy;
  assign parity_ok = ~(^shadow_q ^ link.key_bit);
  assign timer_inc = timer_q + 1'b1;
  assign fail_inc  = (fail_cnt_q == {FW{1'b1}}) ? fail_cnt_q : fail_cnt_q + 1'b1;

  assign link.key_bit_rdy = rdy;
  assign key_out          = key_out_q;
  assign key_valid        = key_valid_q;
  assign err              = err_q;
  assign fail_cnt         = fail_cnt_q;
  assign lockout          = (state_q == S_LOCKOUT);
  assign busy             = (state_q == S_SHIFT)  || (state_q == S_PARITY) ||
                            (state_q == S_COMMIT) || (state_q == S_FAIL);

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      shadow_q    <= '0;
      key_out_q   <= DEFAULT_KEY;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      shadow_q    <= shadow_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  // Next-state logic; key_out only moves in COMMIT or FAIL so the core sees
  // a stable key while a reload frame is being shifted in.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    shadow_d    = shadow_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    fail_cnt_d  = fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (link.start) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          timer_d   = '0;
          shadow_d  = '0;
          err_d     = 1'b0;
        end
      end

      S_SHIFT: begin
        if (xfer) begin
          for (int i = 0; i < KEY_W; i++) begin
            if (bit_cnt_q == BW'(i)) begin
              shadow_d[i] = link.key_bit;
            end
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
          timer_d   = '0;
          if (bit_cnt_q == LAST_BIT_C) begin
            state_d = S_PARITY;
          end
        end else if (timer_inc == TIMEOUT_C) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_PARITY: begin
        if (xfer) begin
          timer_d = '0;
          state_d = parity_ok ? S_COMMIT : S_FAIL;
        end else if (timer_inc == TIMEOUT_C) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_COMMIT: begin
        key_out_d   = shadow_q;
        key_valid_d = 1'b1;
        fail_cnt_d  = '0;
        state_d     = S_IDLE;
      end

      S_FAIL: begin
        err_d       = 1'b1;
        key_valid_d = 1'b0;
        key_out_d   = DEFAULT_KEY;
        fail_cnt_d  = fail_inc;
        state_d     = (fail_inc == MAX_FAIL_C) ? S_LOCKOUT : S_IDLE;
      end

      S_LOCKOUT: begin
        key_out_d   = DEFAULT_KEY;
        key_valid_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_key_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_key_loader
//  Purpose  : Directed bench for lock_key_loader. Frame results are queued as
//             expectations by the stimulus thread and checked by a monitor
//             each time the DUT finishes a frame (busy falls).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lock_key_loader;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_out;
  logic       key_valid;
  logic       busy;
  logic       err;
  logic       lockout;
  logic [1:0] fail_cnt;

  lock_key_loader_if lif ();

  lock_key_loader #(
    .KEY_W       (4),
    .DEFAULT_KEY (4'b0000),
    .TIMEOUT     (16),
    .MAX_FAIL    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (lif),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt)
  );

  typedef struct {
    logic [3:0] key;
    logic       kv;
    logic       er;
    logic       lk;
    logic [1:0] fc;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to check output latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a completed frame is signalled by busy falling.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_end actual=1 required=0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_key_out",   32'(key_out),   32'(e.key));
          chk("sb_key_valid", 32'(key_valid), 32'(e.kv));
          chk("sb_err",       32'(err),       32'(e.er));
          chk("sb_lockout",   32'(lockout),   32'(e.lk));
          chk("sb_fail_cnt",  32'(fail_cnt),  32'(e.fc));
          chk("sb_latency",   32'(cyc),       32'(e.cyc));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic push_exp(input logic [3:0] k, input logic kv, input logic er,
                          input logic lk, input logic [1:0] fc, input int c);
    exp_t e;
    e.key = k; e.kv = kv; e.er = er; e.lk = lk; e.fc = fc; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    lif.start = 1'b1;
    @(posedge clk); #1;
    lif.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    lif.key_bit     = b;
    lif.key_bit_vld = 1'b1;
    @(posedge clk); #1;
    lif.key_bit_vld = 1'b0;
    lif.key_bit     = 1'b0;
  endtask

  // Start a frame, shift k LSB first, then the parity bit.
  task automatic send_frame(input logic [3:0] k, input logic par);
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(k[i]);
    send_bit(par);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_key_out"},   32'(key_out),         32'h0);
    chk({tag, "_key_valid"}, 32'(key_valid),       32'h0);
    chk({tag, "_busy"},      32'(busy),            32'h0);
    chk({tag, "_err"},       32'(err),             32'h0);
    chk({tag, "_lockout"},   32'(lockout),         32'h0);
    chk({tag, "_fail_cnt"},  32'(fail_cnt),        32'h0);
    chk({tag, "_rdy"},       32'(lif.key_bit_rdy), 32'h0);
  endtask

  initial begin
    int n;
    lif.start       = 1'b0;
    lif.key_bit     = 1'b0;
    lif.key_bit_vld = 1'b0;
    rst_n           = 1'b0;
    #2;
    chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Valid-while-not-ready must be ignored in IDLE.
    send_bit(1'b1);
    chk("idle_vld_busy", 32'(busy), 32'h0);

    // T1: 1,0,0,1 + parity 0 -> commit 4'b1001.
    send_frame(4'b1001, 1'b0);
    push_exp(4'b1001, 1'b1, 1'b0, 1'b0, 2'd0, cyc + 1);
    wait_drain("t1");

    // T2: 1,1,0,0 + parity 1 -> parity error.
    send_frame(4'b0011, 1'b1);
    push_exp(4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, cyc + 1);
    wait_drain("t2");

    // T4: two bits then silence -> FAIL on the 16th idle edge.
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    n = cyc;
    push_exp(4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, n + 17);
    wait_drain("t4");

    // T5: load 1001, then reload 0110 while holding the old key.
    send_frame(4'b1001, 1'b0);
    push_exp(4'b1001, 1'b1, 1'b0, 1'b0, 2'd0, cyc + 1);
    wait_drain("t5a");
    pulse_start();
    chk("t5_busy",        32'(busy),      32'h1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t5_mid_key",     32'(key_out),   32'h9);
    chk("t5_mid_valid",   32'(key_valid), 32'h1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("t5_commit_key",  32'(key_out),   32'h9);
    chk("t5_commit_valid",32'(key_valid), 32'h1);
    push_exp(4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, cyc + 1);
    wait_drain("t5b");

    // T3: three bad frames -> lockout.
    send_frame(4'b1111, 1'b1);
    push_exp(4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, cyc + 1);
    wait_drain("t3a");
    send_frame(4'b1111, 1'b1);
    push_exp(4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, cyc + 1);
    wait_drain("t3b");
    send_frame(4'b1111, 1'b1);
    push_exp(4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, cyc + 1);
    wait_drain("t3c");
    send_frame(4'b1001, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("lock_busy",     32'(busy),            32'h0);
    chk("lock_lockout",  32'(lockout),         32'h1);
    chk("lock_rdy",      32'(lif.key_bit_rdy), 32'h0);
    chk("lock_fail_cnt", 32'(fail_cnt),        32'h3);
    chk("lock_key_out",  32'(key_out),         32'h0);
    chk("lock_valid",    32'(key_valid),       32'h0);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("lock_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // T6: load a key, then async reset mid-SHIFT, then reload.
    send_frame(4'b1001, 1'b0);
    push_exp(4'b1001, 1'b1, 1'b0, 1'b0, 2'd0, cyc + 1);
    wait_drain("t6a");
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("t6_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(4'b0101, 1'b0);
    push_exp(4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, cyc + 1);
    wait_drain("t6b");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
